// File: rtl/cellrv32_ring_fifo_pkg.sv
// Shared helpers for the cellrv32 ring-buffer FIFO: parameter sanity
// function and the index-width calculation used to size the pointers.
package cellrv32_ring_fifo_pkg;

  // True when n is a non-zero power of two.
  function automatic logic is_power_of_two_f(input int unsigned n);
    logic res;
    if (n == 32'd0) begin
      res = 1'b0;
    end else begin
      res = ((n & (n - 32'd1)) == 32'd0);
    end
    return res;
  endfunction

  // ceil(log2(n)) with a floor of 1 so a vector of this width is always legal.
  function automatic int unsigned index_width_f(input int unsigned n);
    int unsigned w;
    w = 32'd1;
    for (int i = 1; i < 32; i++) begin
      if ((32'd1 << i) < n) begin
        w = unsigned'(i) + 32'd1;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/cellrv32_ring_fifo.sv
// Single-clock ring-buffer FIFO with registered or combinational read path,
// optional overflow/underflow protection and optional zero-gating of rdata_o.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// Optional checks: define CELLRV32_FIFO_ASSERT_EN to compile in parameter
// errors and run-time warnings on unprotected overflow/underflow.
module cellrv32_ring_fifo
  import cellrv32_ring_fifo_pkg::*;
#(
  parameter int FIFO_DEPTH = 32'd4,
  parameter int FIFO_WIDTH = 32'd32,
  parameter int FIFO_RSYNC = 32'd1,
  parameter int FIFO_SAFE  = 32'd1,
  parameter int FIFO_GATE  = 32'd0
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  clear_i,
  output logic                  half_o,
  input  logic [FIFO_WIDTH-1:0] wdata_i,
  input  logic                  we_i,
  output logic                  free_o,
  input  logic                  re_i,
  output logic [FIFO_WIDTH-1:0] rdata_o,
  output logic                  avail_o
);

  localparam int   IDX_W   = int'(index_width_f(FIFO_DEPTH));
  localparam logic SAFE_EN = (FIFO_SAFE != 32'd0);
  localparam logic GATE_EN = (FIFO_GATE != 32'd0);

  // Internal status (always reflects the current pointers) and qualified enables.
  logic                  avail_s;
  logic                  free_s;
  logic                  half_s;
  logic                  we_ok_s;
  logic                  re_ok_s;
  logic [FIFO_WIDTH-1:0] head_s;

  if (FIFO_DEPTH == 1) begin : g_single

    logic [FIFO_WIDTH-1:0] data_r;
    logic                  valid_r;

    // A single entry is simply full or empty: every status bit follows the valid flag.
    always_comb begin
      avail_s = valid_r;
      free_s  = ~valid_r;
      half_s  = valid_r;
      head_s  = data_r;
      we_ok_s = we_i & (~valid_r | ~SAFE_EN);
      re_ok_s = re_i & (valid_r | ~SAFE_EN);
    end

    // Valid flag: a simultaneous accepted write and read leaves the level unchanged.
    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        valid_r <= 1'b0;
      end else if (clear_i) begin
        valid_r <= 1'b0;
      end else if (we_ok_s && re_ok_s) begin
        valid_r <= valid_r;
      end else if (we_ok_s) begin
        valid_r <= 1'b1;
      end else if (re_ok_s) begin
        valid_r <= 1'b0;
      end else begin
        valid_r <= valid_r;
      end
    end

    // Data storage is not reset; only the valid flag defines its meaning.
    always_ff @(posedge clk_i) begin
      if (we_ok_s && !clear_i) begin
        data_r <= wdata_i;
      end
    end

  end else begin : g_ring

    localparam logic [IDX_W:0] PTR_ONE  = {{IDX_W{1'b0}}, 1'b1};
    localparam logic [IDX_W:0] HALF_LVL = (IDX_W + 1)'(FIFO_DEPTH / 2);

    logic [IDX_W:0]        w_ptr_r;
    logic [IDX_W:0]        r_ptr_r;
    logic [IDX_W:0]        level_s;
    logic                  empty_s;
    logic                  full_s;
    logic [FIFO_WIDTH-1:0] mem_r [FIFO_DEPTH];

    // Status from the wrap-bit pointers; enables are qualified by pre-edge status.
    always_comb begin
      empty_s = (w_ptr_r == r_ptr_r);
      full_s  = (w_ptr_r[IDX_W-1:0] == r_ptr_r[IDX_W-1:0]) &&
                (w_ptr_r[IDX_W] != r_ptr_r[IDX_W]);
      level_s = w_ptr_r - r_ptr_r;
      avail_s = ~empty_s;
      free_s  = ~full_s;
      half_s  = (level_s >= HALF_LVL);
      head_s  = mem_r[r_ptr_r[IDX_W-1:0]];
      we_ok_s = we_i & (~full_s | ~SAFE_EN);
      re_ok_s = re_i & (~empty_s | ~SAFE_EN);
    end

    // Pointer advance; clear flushes both pointers and wins over any access.
    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        w_ptr_r <= {(IDX_W + 1){1'b0}};
        r_ptr_r <= {(IDX_W + 1){1'b0}};
      end else if (clear_i) begin
        w_ptr_r <= {(IDX_W + 1){1'b0}};
        r_ptr_r <= {(IDX_W + 1){1'b0}};
      end else begin
        if (we_ok_s) begin
          w_ptr_r <= w_ptr_r + PTR_ONE;
        end
        if (re_ok_s) begin
          r_ptr_r <= r_ptr_r + PTR_ONE;
        end
      end
    end

    // Storage array, written at the low bits of the write pointer; never reset.
    always_ff @(posedge clk_i) begin
      if (we_ok_s && !clear_i) begin
        mem_r[w_ptr_r[IDX_W-1:0]] <= wdata_i;
      end
    end

  end

  if (FIFO_RSYNC != 0) begin : g_rsync

    // Registered read path: head data and status lag the pointers by one edge.
    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        rdata_o <= {FIFO_WIDTH{1'b0}};
        avail_o <= 1'b0;
        free_o  <= 1'b1;
        half_o  <= 1'b0;
      end else begin
        avail_o <= avail_s;
        free_o  <= free_s;
        half_o  <= half_s;
        if (GATE_EN && !avail_s) begin
          rdata_o <= {FIFO_WIDTH{1'b0}};
        end else begin
          rdata_o <= head_s;
        end
      end
    end

  end else begin : g_rcomb

    // Combinational read path: outputs follow the pointers directly.
    always_comb begin
      avail_o = avail_s;
      free_o  = free_s;
      half_o  = half_s;
      if (GATE_EN && !avail_s) begin
        rdata_o = {FIFO_WIDTH{1'b0}};
      end else begin
        rdata_o = head_s;
      end
    end

  end

`ifdef CELLRV32_FIFO_ASSERT_EN
  if (!is_power_of_two_f(FIFO_DEPTH)) begin : g_chk_depth
    $error("cellrv32_ring_fifo: FIFO_DEPTH must be a power of two >= 1");
  end
  if (FIFO_WIDTH < 1) begin : g_chk_width
    $error("cellrv32_ring_fifo: FIFO_WIDTH must be >= 1");
  end

  // Flag accesses that corrupt state when the protection is disabled.
  always @(posedge clk_i) begin
    if (rstn_i && !clear_i && !SAFE_EN) begin
      if (we_i && !free_s) begin
        $warning("cellrv32_ring_fifo: write while full");
      end
      if (re_i && !avail_s) begin
        $warning("cellrv32_ring_fifo: read while empty");
      end
    end
  end
`endif

endmodule

// File: tb/tb_cellrv32_ring_fifo.sv
// Self-checking bench for cellrv32_ring_fifo. Three instances:
//   A: depth 4, width 8,  registered read path, protected, no gating
//   B: depth 1, width 8,  combinational read path, protected, gated
//   C: depth 8, width 16, combinational read path, protected, gated
// Each instance is mirrored by a queue; expected outputs are computed from
// queue occupancy and head, with A's outputs taken from the pre-edge queue.
module tb_cellrv32_ring_fifo;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       a_clr, a_we, a_re, a_half, a_free, a_avail;
  logic [7:0] a_wd, a_rd;
  logic       b_clr, b_we, b_re, b_half, b_free, b_avail;
  logic [7:0] b_wd, b_rd;
  logic        c_clr, c_we, c_re, c_half, c_free, c_avail;
  logic [15:0] c_wd, c_rd;

  cellrv32_ring_fifo #(.FIFO_DEPTH(4), .FIFO_WIDTH(8), .FIFO_RSYNC(1), .FIFO_SAFE(1), .FIFO_GATE(0)) u_a (
    .clk_i(clk), .rstn_i(rst_n), .clear_i(a_clr), .half_o(a_half), .wdata_i(a_wd),
    .we_i(a_we), .free_o(a_free), .re_i(a_re), .rdata_o(a_rd), .avail_o(a_avail));

  cellrv32_ring_fifo #(.FIFO_DEPTH(1), .FIFO_WIDTH(8), .FIFO_RSYNC(0), .FIFO_SAFE(1), .FIFO_GATE(1)) u_b (
    .clk_i(clk), .rstn_i(rst_n), .clear_i(b_clr), .half_o(b_half), .wdata_i(b_wd),
    .we_i(b_we), .free_o(b_free), .re_i(b_re), .rdata_o(b_rd), .avail_o(b_avail));

  cellrv32_ring_fifo #(.FIFO_DEPTH(8), .FIFO_WIDTH(16), .FIFO_RSYNC(0), .FIFO_SAFE(1), .FIFO_GATE(1)) u_c (
    .clk_i(clk), .rstn_i(rst_n), .clear_i(c_clr), .half_o(c_half), .wdata_i(c_wd),
    .we_i(c_we), .free_o(c_free), .re_i(c_re), .rdata_o(c_rd), .avail_o(c_avail));

  int nvec = 0;
  int nerr = 0;

  logic [7:0]  qa[$];
  logic [7:0]  qb[$];
  logic [15:0] qc[$];

  logic        ea_avail, ea_free, ea_half;
  logic [7:0]  ea_rd;
  logic        eb_avail, eb_free, eb_half;
  logic [7:0]  eb_rd;
  logic        ec_avail, ec_free, ec_half;
  logic [15:0] ec_rd;

  task automatic idle();
    a_clr = 1'b0; a_we = 1'b0; a_re = 1'b0; a_wd = 8'h00;
    b_clr = 1'b0; b_we = 1'b0; b_re = 1'b0; b_wd = 8'h00;
    c_clr = 1'b0; c_we = 1'b0; c_re = 1'b0; c_wd = 16'h0000;
  endtask

  // One clock edge: apply the held inputs to the queue models and derive expectations.
  task automatic tick();
    bit dr, dw;
    // A is registered: what it shows after this edge is the state before it.
    ea_avail = (qa.size() > 0);
    ea_free  = (qa.size() < 4);
    ea_half  = (qa.size() >= 2);
    ea_rd    = ea_avail ? qa[0] : 8'h00;
    @(posedge clk);
    #1;
    if (a_clr) qa.delete();
    else begin
      dr = a_re && (qa.size() > 0);
      dw = a_we && (qa.size() < 4);
      if (dr) void'(qa.pop_front());
      if (dw) qa.push_back(a_wd);
    end
    if (b_clr) qb.delete();
    else begin
      dr = b_re && (qb.size() > 0);
      dw = b_we && (qb.size() < 1);
      if (dr) void'(qb.pop_front());
      if (dw) qb.push_back(b_wd);
    end
    if (c_clr) qc.delete();
    else begin
      dr = c_re && (qc.size() > 0);
      dw = c_we && (qc.size() < 8);
      if (dr) void'(qc.pop_front());
      if (dw) qc.push_back(c_wd);
    end
    eb_avail = (qb.size() > 0);
    eb_free  = (qb.size() < 1);
    eb_half  = (qb.size() >= 1);
    eb_rd    = eb_avail ? qb[0] : 8'h00;
    ec_avail = (qc.size() > 0);
    ec_free  = (qc.size() < 8);
    ec_half  = (qc.size() >= 4);
    ec_rd    = ec_avail ? qc[0] : 16'h0000;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    nvec++;
    if ({a_avail, a_free, a_half, a_rd} !== {1'b0, 1'b1, 1'b0, 8'h00}) begin
      nerr++; $display("FAIL reset_a: got %h want %h", {a_avail, a_free, a_half, a_rd}, {1'b0, 1'b1, 1'b0, 8'h00});
    end
    nvec++;
    if ({b_avail, b_free, b_half, b_rd} !== {1'b0, 1'b1, 1'b0, 8'h00}) begin
      nerr++; $display("FAIL reset_b: got %h want %h", {b_avail, b_free, b_half, b_rd}, {1'b0, 1'b1, 1'b0, 8'h00});
    end
    nvec++;
    if ({c_avail, c_free, c_half, c_rd} !== {1'b0, 1'b1, 1'b0, 16'h0000}) begin
      nerr++; $display("FAIL reset_c: got %h want %h", {c_avail, c_free, c_half, c_rd}, {1'b0, 1'b1, 1'b0, 16'h0000});
    end
    rst_n = 1'b1;
  endtask

  // Fill to full, attempt an overflow, simultaneous access while full, then drain.
  task automatic test_fill_drain();
    // {we, re, data}
    logic [9:0] ops [16] = '{10'h211, 10'h222, 10'h233, 10'h244, 10'h000, 10'h255, 10'h000,
                             10'h366, 10'h000, 10'h100, 10'h100, 10'h100, 10'h100, 10'h000,
                             10'h000, 10'h000};
    for (int i = 0; i < 16; i++) begin
      idle();
      a_we = ops[i][9]; a_re = ops[i][8]; a_wd = ops[i][7:0];
      tick();
      nvec++;
      if ({a_avail, a_free, a_half} !== {ea_avail, ea_free, ea_half}) begin
        nerr++; $display("FAIL fill_drain.status step %0d: got %b want %b", i, {a_avail, a_free, a_half}, {ea_avail, ea_free, ea_half});
      end
      if (ea_avail) begin
        nvec++;
        if (a_rd !== ea_rd) begin
          nerr++; $display("FAIL fill_drain.rdata step %0d: got %h want %h", i, a_rd, ea_rd);
        end
      end
    end
  endtask

  // Simultaneous read and write at a half-full level keeps the level and order.
  task automatic test_simul_half();
    logic [9:0] ops [10] = '{10'h2a1, 10'h2a2, 10'h3b1, 10'h3b2, 10'h3b3, 10'h000,
                             10'h100, 10'h100, 10'h000, 10'h000};
    for (int i = 0; i < 10; i++) begin
      idle();
      a_we = ops[i][9]; a_re = ops[i][8]; a_wd = ops[i][7:0];
      tick();
      nvec++;
      if ({a_avail, a_free, a_half} !== {ea_avail, ea_free, ea_half}) begin
        nerr++; $display("FAIL simul_half.status step %0d: got %b want %b", i, {a_avail, a_free, a_half}, {ea_avail, ea_free, ea_half});
      end
      if (ea_avail) begin
        nvec++;
        if (a_rd !== ea_rd) begin
          nerr++; $display("FAIL simul_half.rdata step %0d: got %h want %h", i, a_rd, ea_rd);
        end
      end
    end
  endtask

  // Clear with a concurrent write flushes the FIFO; the write is discarded.
  task automatic test_clear();
    for (int i = 0; i < 7; i++) begin
      idle();
      if (i < 3) begin
        a_we = 1'b1; a_wd = 8'(8'h70 + i);
      end else if (i == 3) begin
        a_clr = 1'b1; a_we = 1'b1; a_wd = 8'hee;
      end
      tick();
      nvec++;
      if ({a_avail, a_free, a_half} !== {ea_avail, ea_free, ea_half}) begin
        nerr++; $display("FAIL clear.status step %0d: got %b want %b", i, {a_avail, a_free, a_half}, {ea_avail, ea_free, ea_half});
      end
      if (ea_avail) begin
        nvec++;
        if (a_rd !== ea_rd) begin
          nerr++; $display("FAIL clear.rdata step %0d: got %h want %h", i, a_rd, ea_rd);
        end
      end
    end
  endtask

  // Depth-1 instance with zero-gated, combinational read data.
  task automatic test_gate_depth1();
    logic [9:0] ops [11] = '{10'h000, 10'h2a5, 10'h000, 10'h100, 10'h000, 10'h23c,
                             10'h277, 10'h388, 10'h000, 10'h399, 10'h100};
    for (int i = 0; i < 11; i++) begin
      idle();
      b_we = ops[i][9]; b_re = ops[i][8]; b_wd = ops[i][7:0];
      tick();
      nvec++;
      if ({b_avail, b_free, b_half, b_rd} !== {eb_avail, eb_free, eb_half, eb_rd}) begin
        nerr++; $display("FAIL gate_depth1 step %0d: got %h want %h", i, {b_avail, b_free, b_half, b_rd}, {eb_avail, eb_free, eb_half, eb_rd});
      end
    end
  endtask

  // Reset asserted between edges must take effect without a clock edge.
  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      idle();
      a_we = 1'b1; a_wd = 8'($urandom);
      b_we = 1'b1; b_wd = 8'($urandom);
      c_we = 1'b1; c_wd = 16'($urandom);
      tick();
    end
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    nvec++;
    if ({a_avail, a_free, a_half, a_rd} !== {1'b0, 1'b1, 1'b0, 8'h00}) begin
      nerr++; $display("FAIL async_reset_a: got %h want %h", {a_avail, a_free, a_half, a_rd}, {1'b0, 1'b1, 1'b0, 8'h00});
    end
    nvec++;
    if ({b_avail, b_free, b_half, b_rd} !== {1'b0, 1'b1, 1'b0, 8'h00}) begin
      nerr++; $display("FAIL async_reset_b: got %h want %h", {b_avail, b_free, b_half, b_rd}, {1'b0, 1'b1, 1'b0, 8'h00});
    end
    nvec++;
    if ({c_avail, c_free, c_half, c_rd} !== {1'b0, 1'b1, 1'b0, 16'h0000}) begin
      nerr++; $display("FAIL async_reset_c: got %h want %h", {c_avail, c_free, c_half, c_rd}, {1'b0, 1'b1, 1'b0, 16'h0000});
    end
    qa.delete(); qb.delete(); qc.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Random traffic on all three instances, including blocked accesses and clears.
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      idle();
      a_we = ($urandom_range(0, 9) < 6); a_re = ($urandom_range(0, 9) < 4); a_wd = 8'($urandom);
      a_clr = ($urandom_range(0, 39) == 0);
      b_we = 1'($urandom_range(0, 1)); b_re = 1'($urandom_range(0, 1)); b_wd = 8'($urandom);
      b_clr = ($urandom_range(0, 39) == 0);
      c_we = ($urandom_range(0, 9) < 5); c_re = ($urandom_range(0, 9) < 5); c_wd = 16'($urandom);
      c_clr = ($urandom_range(0, 39) == 0);
      tick();
      nvec++;
      if ({a_avail, a_free, a_half} !== {ea_avail, ea_free, ea_half}) begin
        nerr++; $display("FAIL random_a.status cycle %0d: got %b want %b", i, {a_avail, a_free, a_half}, {ea_avail, ea_free, ea_half});
      end
      if (ea_avail) begin
        nvec++;
        if (a_rd !== ea_rd) begin
          nerr++; $display("FAIL random_a.rdata cycle %0d: got %h want %h", i, a_rd, ea_rd);
        end
      end
      nvec++;
      if ({b_avail, b_free, b_half, b_rd} !== {eb_avail, eb_free, eb_half, eb_rd}) begin
        nerr++; $display("FAIL random_b cycle %0d: got %h want %h", i, {b_avail, b_free, b_half, b_rd}, {eb_avail, eb_free, eb_half, eb_rd});
      end
      nvec++;
      if ({c_avail, c_free, c_half, c_rd} !== {ec_avail, ec_free, ec_half, ec_rd}) begin
        nerr++; $display("FAIL random_c cycle %0d: got %h want %h", i, {c_avail, c_free, c_half, c_rd}, {ec_avail, ec_free, ec_half, ec_rd});
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_simul_half();
    test_clear();
    test_gate_depth1();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
